// File: rtl/or1k_branch_predict_ctrl.sv
// Agree-style branch predictor with in-flight branch queue.
// Statistics counters are built only when OR1K_BP_STATS_EN is defined.
module or1k_branch_predict_ctrl #(
  parameter int OPTION_BP_PENDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        padv_decode_i,
  input  logic        op_bf_i,
  input  logic        op_bnf_i,
  input  logic [9:0]  immjbr_upper_i,
  output logic        predicted_flag_o,
  output logic        stall_o,
  input  logic        branch_resolve_i,
  input  logic        flag_i,
  input  logic        pipeline_flush_i,
  output logic        mispredict_o,
  output logic        pending_empty_o,
  output logic        pending_full_o,
  output logic [15:0] branch_count_o,
  output logic [15:0] mispredict_count_o
);

  localparam int PW = $clog2(OPTION_BP_PENDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(OPTION_BP_PENDING);

  logic          is_br;
  logic          s_flag;
  logic          push;
  logic          pop;
  logic          agree;
  logic [1:0]    head;
  logic [1:0]    mem_q [OPTION_BP_PENDING];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ctr_q, ctr_d;
  logic          mp_q, mp_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          unused_imm;

  assign unused_imm = ^immjbr_upper_i[8:0];

  assign is_br  = op_bf_i | op_bnf_i;
  assign s_flag = (op_bf_i & immjbr_upper_i[9]) |
                  (op_bnf_i & ~immjbr_upper_i[9]);

  assign predicted_flag_o = is_br & (ctr_q[1] ? s_flag : ~s_flag);

  // A same-cycle pop frees a slot, so a full queue may still accept.
  assign stall_o = is_br & full_q &
                   ~(branch_resolve_i & ~pipeline_flush_i);

  assign push = padv_decode_i & is_br & ~stall_o & ~pipeline_flush_i;
  assign pop  = branch_resolve_i & ~empty_q & ~pipeline_flush_i;

  assign head  = mem_q[rd_q];
  assign agree = (flag_i == head[0]);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ctr_d = ctr_q;
    mp_d  = 1'b0;
    if (pipeline_flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
        mp_d = head[1] ^ flag_i;
        if (agree) begin
          ctr_d = (ctr_q == 2'b11) ? ctr_q : ctr_q + 2'b01;
        end else begin
          ctr_d = (ctr_q == 2'b00) ? ctr_q : ctr_q - 2'b01;
        end
      end
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ctr_q   <= 2'b10;
      mp_q    <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ctr_q   <= ctr_d;
      mp_q    <= mp_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Entry payload: {prediction, static flag}.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {predicted_flag_o, s_flag};
    end
  end

  assign mispredict_o    = mp_q;
  assign pending_empty_o = empty_q;
  assign pending_full_o  = full_q;

`ifdef OR1K_BP_STATS_EN
  logic [15:0] bcnt_q;
  logic [15:0] mcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (pop && bcnt_q != 16'hFFFF) begin
        bcnt_q <= bcnt_q + 16'd1;
      end
      if (mp_d && mcnt_q != 16'hFFFF) begin
        mcnt_q <= mcnt_q + 16'd1;
      end
    end
  end

  assign branch_count_o     = bcnt_q;
  assign mispredict_count_o = mcnt_q;
`else
  assign branch_count_o     = 16'h0000;
  assign mispredict_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_or1k_branch_predict_ctrl.sv
// Directed bench for or1k_branch_predict_ctrl with a mispredict scoreboard.
// Statistics checks follow OR1K_BP_STATS_EN.
module tb_or1k_branch_predict_ctrl;

  localparam logic [9:0] BK = 10'h200;
  localparam logic [9:0] FW = 10'h000;

  logic        clk;
  logic        rst;
  logic        padv_decode_i;
  logic        op_bf_i;
  logic        op_bnf_i;
  logic [9:0]  immjbr_upper_i;
  logic        predicted_flag_o;
  logic        stall_o;
  logic        branch_resolve_i;
  logic        flag_i;
  logic        pipeline_flush_i;
  logic        mispredict_o;
  logic        pending_empty_o;
  logic        pending_full_o;
  logic [15:0] branch_count_o;
  logic [15:0] mispredict_count_o;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  or1k_branch_predict_ctrl #(.OPTION_BP_PENDING(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .padv_decode_i      (padv_decode_i),
    .op_bf_i            (op_bf_i),
    .op_bnf_i           (op_bnf_i),
    .immjbr_upper_i     (immjbr_upper_i),
    .predicted_flag_o   (predicted_flag_o),
    .stall_o            (stall_o),
    .branch_resolve_i   (branch_resolve_i),
    .flag_i             (flag_i),
    .pipeline_flush_i   (pipeline_flush_i),
    .mispredict_o       (mispredict_o),
    .pending_empty_o    (pending_empty_o),
    .pending_full_o     (pending_full_o),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic e, input logic f);
    chk({tag, "_empty"}, 16'(pending_empty_o), 16'(e));
    chk({tag, "_full"}, 16'(pending_full_o), 16'(f));
  endtask

  task automatic stats(input string tag, input logic [15:0] b,
                       input logic [15:0] m);
`ifdef OR1K_BP_STATS_EN
    chk({tag, "_bcnt"}, branch_count_o, b);
    chk({tag, "_mcnt"}, mispredict_count_o, m);
`else
    chk({tag, "_bcnt"}, branch_count_o, 16'h0000 & b);
    chk({tag, "_mcnt"}, mispredict_count_o, 16'h0000 & m);
`endif
  endtask

  // One cycle: drive, check comb outputs, clock, check mispredict pulse.
  task automatic cyc(input string tag, input logic padv, input logic bf,
                     input logic bnf, input logic [9:0] imm,
                     input logic res, input logic fl, input logic flush,
                     input logic ep, input logic es, input logic emp);
    logic e;
    padv_decode_i    = padv;
    op_bf_i          = bf;
    op_bnf_i         = bnf;
    immjbr_upper_i   = imm;
    branch_resolve_i = res;
    flag_i           = fl;
    pipeline_flush_i = flush;
    #1;
    chk({tag, "_pred"}, 16'(predicted_flag_o), 16'(ep));
    chk({tag, "_stall"}, 16'(stall_o), 16'(es));
    exp_q.push_back(emp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_mp"}, 16'(mispredict_o), 16'(e));
    padv_decode_i    = 1'b0;
    op_bf_i          = 1'b0;
    op_bnf_i         = 1'b0;
    immjbr_upper_i   = '0;
    branch_resolve_i = 1'b0;
    flag_i           = 1'b0;
    pipeline_flush_i = 1'b0;
  endtask

  initial begin
    logic ep_a[4];
    logic p_old;
    logic p_new;
    ep_a = '{1'b1, 1'b1, 1'b0, 1'b0};
    rst              = 1'b1;
    padv_decode_i    = 1'b0;
    op_bf_i          = 1'b0;
    op_bnf_i         = 1'b0;
    immjbr_upper_i   = '0;
    branch_resolve_i = 1'b0;
    flag_i           = 1'b0;
    pipeline_flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    st("rst", 1'b1, 1'b0);
    chk("rst_mp", 16'(mispredict_o), 16'h0);
    chk("rst_pred_idle", 16'(predicted_flag_o), 16'h0);
    stats("rst", 16'd0, 16'd0);

    // Backward l.bf predicted taken, resolves not-taken.
    cyc("t1_push", 1, 1, 0, BK, 0, 0, 0, 1, 0, 0);
    st("t1_q1", 1'b0, 1'b0);
    cyc("t1_res", 0, 0, 0, FW, 1, 0, 0, 0, 0, 1);
    st("t1_q0", 1'b1, 1'b0);
    cyc("t1_c01", 0, 1, 0, BK, 0, 0, 0, 0, 0, 0);

    // Fill, stall, then push and pop together while full.
    cyc("t2_p1", 1, 0, 1, FW, 0, 0, 0, 0, 0, 0);
    st("t2_q1", 1'b0, 1'b0);
    cyc("t2_p2", 1, 0, 1, FW, 0, 0, 0, 0, 0, 0);
    st("t2_q2", 1'b0, 1'b1);
    cyc("t2_stall", 1, 0, 1, FW, 0, 0, 0, 0, 1, 0);
    st("t2_q2b", 1'b0, 1'b1);
    cyc("t2_both", 1, 0, 1, FW, 1, 1, 0, 0, 0, 1);
    st("t2_q2c", 1'b0, 1'b1);

    // Agree to saturation, then disagree to saturation.
    cyc("t3_a1", 0, 0, 0, FW, 1, 1, 0, 0, 0, 1);
    cyc("t3_a2", 0, 0, 0, FW, 1, 1, 0, 0, 0, 1);
    st("t3_q0", 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cyc("t3_ap", 1, 1, 0, BK, 0, 0, 0, 1, 0, 0);
      cyc("t3_ar", 0, 0, 0, FW, 1, 1, 0, 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc("t3_dp", 1, 1, 0, BK, 0, 0, 0, ep_a[k], 0, 0);
      cyc("t3_dr", 0, 0, 0, FW, 1, 0, 0, 0, 0, ep_a[k]);
    end
    cyc("t3_c00", 0, 1, 0, BK, 0, 0, 0, 0, 0, 0);
    stats("t3", 16'd10, 16'd6);

    // Flush beats same-cycle resolve and push.
    cyc("t4_p1", 1, 0, 1, FW, 0, 0, 0, 0, 0, 0);
    cyc("t4_p2", 1, 0, 1, FW, 0, 0, 0, 0, 0, 0);
    st("t4_q2", 1'b0, 1'b1);
    cyc("t4_flush", 1, 0, 1, FW, 1, 1, 1, 0, 1, 0);
    st("t4_q0", 1'b1, 1'b0);
    cyc("t4_p3", 1, 1, 0, BK, 0, 0, 0, 0, 0, 0);
    cyc("t4_r3", 0, 0, 0, FW, 1, 1, 0, 0, 0, 1);
    cyc("t4_p4", 1, 1, 0, BK, 0, 0, 0, 0, 0, 0);
    cyc("t4_r4", 0, 0, 0, FW, 1, 1, 0, 0, 0, 1);

    // Resolve against an empty queue is ignored.
    cyc("t5_eres", 0, 0, 0, FW, 1, 0, 0, 0, 0, 0);
    st("t5_q0", 1'b1, 1'b0);
    cyc("t5_c10", 0, 1, 0, BK, 0, 0, 0, 1, 0, 0);
    stats("t5", 16'd12, 16'd8);

    // Drive C to 00 with two queued, then reset.
    cyc("t6_p1", 1, 1, 0, BK, 0, 0, 0, 1, 0, 0);
    cyc("t6_r1", 0, 0, 0, FW, 1, 0, 0, 0, 0, 1);
    cyc("t6_p2", 1, 1, 0, BK, 0, 0, 0, 0, 0, 0);
    cyc("t6_r2", 0, 0, 0, FW, 1, 0, 0, 0, 0, 0);
    cyc("t6_p3", 1, 1, 0, BK, 0, 0, 0, 0, 0, 0);
    cyc("t6_p4", 1, 1, 0, BK, 0, 0, 0, 0, 0, 0);
    st("t6_q2", 1'b0, 1'b1);
    rst = 1'b1;
    cyc("t6_rst", 0, 0, 0, FW, 1, 1, 0, 0, 0, 0);
    rst = 1'b0;
    st("t6_q0", 1'b1, 1'b0);
    stats("t6", 16'd0, 16'd0);
    cyc("t6_c10", 0, 1, 0, BK, 0, 0, 0, 1, 0, 0);

`ifdef OR1K_BP_STATS_EN
    // Stream push+pop with every resolve opposite its prediction.
    padv_decode_i  = 1'b1;
    op_bf_i        = 1'b1;
    immjbr_upper_i = BK;
    #1;
    p_old = predicted_flag_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < 65536; i++) begin
      branch_resolve_i = 1'b1;
      flag_i           = ~p_old;
      #1;
      p_new = predicted_flag_o;
      @(posedge clk);
      #1;
      p_old = p_new;
    end
    padv_decode_i    = 1'b0;
    op_bf_i          = 1'b0;
    branch_resolve_i = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_bcnt", branch_count_o, 16'hFFFF);
    chk("sat_mcnt", mispredict_count_o, 16'hFFFF);
`else
    p_old = 1'b0;
    p_new = p_old;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/or1k_branch_predict_ctrl.md
OR1K_BRANCH_PREDICT_CTRL -- requirements
Module: or1k_branch_predict_ctrl

Interface
REQ-001 Parameter: OPTION_BP_PENDING, default 2, in-flight branch queue depth; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 padv_decode_i  input  1  decode stage advances this cycle.
REQ-005 op_bf_i  input  1  decode holds l.bf.
REQ-006 op_bnf_i  input  1  decode holds l.bnf.
REQ-007 immjbr_upper_i  input  10  upper branch offset bits; bit 9 is the sign.
REQ-008 predicted_flag_o  output  1  predicted flag for the decode branch, combinational.
REQ-009 stall_o  output  1  decode branch cannot be queued this cycle, combinational.
REQ-010 branch_resolve_i  input  1  execute resolves the oldest queued branch.
REQ-011 flag_i  input  1  actual flag at resolve.
REQ-012 pipeline_flush_i  input  1  discard all in-flight branches.
REQ-013 mispredict_o  output  1  registered one-cycle mispredict pulse.
REQ-014 pending_empty_o / pending_full_o  output  1 each  queue status, registered.
REQ-015 branch_count_o / mispredict_count_o  output  16 each  statistics (see Configuration).

Function
REQ-016 Static flag S = op_bf_i & immjbr_upper_i[9] | op_bnf_i & ~immjbr_upper_i[9].
REQ-017 Agree counter C (2-bit saturating): 00 strong-disagree, 01 weak-disagree, 10 weak-agree, 11 strong-agree.
REQ-018 predicted_flag_o = S when C[1]=1, ~S when C[1]=0; driven 0 when no branch in decode.
REQ-019 Push = padv_decode_i & (op_bf_i|op_bnf_i) & ~stall_o; entry stores {predicted_flag_o, S}.
REQ-020 stall_o = (op_bf_i|op_bnf_i) & full & ~(branch_resolve_i & ~pipeline_flush_i).
REQ-021 Pop = branch_resolve_i & ~empty & ~pipeline_flush_i; resolve when empty is ignored (no pop, no update, no pulse).
REQ-022 On pop: agree = (flag_i == stored S); C increments (saturates at 11) if agree, else decrements (saturates at 00).
REQ-023 On pop: mispredict_o=1 the following cycle when stored prediction != flag_i; otherwise 0.
REQ-024 Prediction in a cycle uses C before any same-cycle update.
REQ-025 Simultaneous push and pop: both occur; occupancy unchanged; allowed when full.
REQ-026 Read/write pointers wrap modulo OPTION_BP_PENDING; occupancy counter is log2(depth)+1 bits.
REQ-027 pipeline_flush_i: queue emptied next cycle, overrides same-cycle push and pop; C unchanged; no mispredict pulse.

Reset
REQ-028 rst in any state, including mid-queue: queue empty, C=10, mispredict_o=0, pending_empty_o=1, pending_full_o=0, statistics 0.
REQ-029 rst has priority over flush, push and pop.

Configuration
REQ-030 Macro OR1K_BP_STATS_EN defined: branch_count_o increments per pop, mispredict_count_o per mispredict; both saturate at 16'hFFFF.
REQ-031 Macro OR1K_BP_STATS_EN undefined: no counter registers; both ports tied to 0; all other behaviour identical.

Verification
REQ-032 After rst, l.bf with immjbr_upper_i=10'h200 -> predicted_flag_o=1; resolve flag_i=0 -> mispredict_o=1 next cycle, C=01.
REQ-033 Two l.bnf forward pushes (depth 2) -> pending_full_o=1; third branch without resolve -> stall_o=1; with branch_resolve_i same cycle -> stall_o=0, push accepted, still full.
REQ-034 Four consecutive agreeing resolves from C=10 -> C stays 11; four disagreeing -> C=00, next l.bf backward predicts 0.
REQ-035 pipeline_flush_i with branch_resolve_i and push in same cycle on 2 queued -> pending_empty_o=1 next cycle, mispredict_o=0, C unchanged.
REQ-036 branch_resolve_i with empty queue -> no pulse, C and counters unchanged; with OR1K_BP_STATS_EN, 65536 mispredicts -> mispredict_count_o=16'hFFFF.
REQ-037 rst asserted with 2 queued and C=00 -> next cycle empty, C=10, all outputs at reset values.
